// File: rtl/fft_pkg.sv
// Shared types and constants for the 32-point FFT datapath.
package fft_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int N_POINTS   = 32;
  localparam int LOG2_N     = $clog2(N_POINTS);

  typedef logic [LOG2_N-1:0]            fft_idx_t;
  typedef logic [N_POINTS*DATA_WIDTH-1:0] fft_bus_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex-sample storage, written one slot at a time and
// read out in parallel as flat real/imag buses (slot k at [(k+1)*dw-1 : k*dw]).
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int dw = DATA_WIDTH,
  parameter int n  = N_POINTS
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(n)-1:0]   waddr,
  input  logic [dw-1:0]          wdata_real,
  input  logic [dw-1:0]          wdata_imag,
  output logic [n*dw-1:0]        bus_real,
  output logic [n*dw-1:0]        bus_imag
);

  localparam int aw = $clog2(n);

  for (genvar k = 0; k < n; k++) begin : g_slot
    logic [dw-1:0] slot_real;
    logic [dw-1:0] slot_imag;

    // Capture the incoming sample into this slot when it is addressed.
    // NOTE: storage carries no reset; the control's full flags decide whether
    // the contents are meaningful, and the output mux zero-gates them otherwise.
    always_ff @(posedge clk) begin
      if (we && (waddr == aw'(k))) begin
        slot_real <= wdata_real;
        slot_imag <= wdata_imag;
      end
    end

    assign bus_real[k*dw +: dw] = slot_real;
    assign bus_imag[k*dw +: dw] = slot_imag;
  end

endmodule

// File: rtl/fft_frame_collector.sv
// Serial-to-parallel ping-pong frame collector feeding the FFT stage-0 mapper.
// One bank fills while the other holds a complete frame for the consumer.
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int no_in_out  = N_POINTS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [data_width-1:0]           in_real,
  input  logic [data_width-1:0]           in_imag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [no_in_out*data_width-1:0] output_data_real,
  output logic [no_in_out*data_width-1:0] output_data_imag
);

  localparam int              aw        = $clog2(no_in_out);
  localparam logic [aw-1:0]   last_slot = aw'(no_in_out - 1);

  logic [aw-1:0] wr_ptr;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;

  logic accept;
  logic xfer;
  logic last_accept;

  logic [no_in_out*data_width-1:0] bank0_real, bank0_imag;
  logic [no_in_out*data_width-1:0] bank1_real, bank1_imag;

  // Handshake: ready/valid derive only from registered flags, gated off in reset.
  assign in_ready    = !rst && !full[wr_bank];
  assign out_valid   = !rst && full[rd_bank];
  assign accept      = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;
  assign last_accept = accept && (wr_ptr == last_slot);

  // Write pointer, bank selects and full flags. A last-sample accept and an
  // output transfer in the same cycle always target different banks.
  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (last_accept) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (xfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  fft_frame_bank #(.dw(data_width), .n(no_in_out)) u_bank0 (
    .clk        (clk),
    .we         (accept && !wr_bank),
    .waddr      (wr_ptr),
    .wdata_real (in_real),
    .wdata_imag (in_imag),
    .bus_real   (bank0_real),
    .bus_imag   (bank0_imag)
  );

  fft_frame_bank #(.dw(data_width), .n(no_in_out)) u_bank1 (
    .clk        (clk),
    .we         (accept && wr_bank),
    .waddr      (wr_ptr),
    .wdata_real (in_real),
    .wdata_imag (in_imag),
    .bus_real   (bank1_real),
    .bus_imag   (bank1_imag)
  );

  // Present the read bank while a frame is valid, zeros otherwise.
  assign output_data_real = out_valid ? (rd_bank ? bank1_real : bank0_real) : '0;
  assign output_data_imag = out_valid ? (rd_bank ? bank1_imag : bank0_imag) : '0;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed and scoreboard-backed bench for fft_frame_collector.
module tb_fft_frame_collector;

  localparam int DW = 8;
  localparam int N  = 32;
  localparam int BW = DW * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_imag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_r;
  logic [BW-1:0] out_i;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  logic [2*DW-1:0] sb [$];

  always #5 clk = ~clk;

  fft_frame_collector #(.data_width(DW), .no_in_out(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_real          (in_real),
    .in_imag          (in_imag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .output_data_real (out_r),
    .output_data_imag (out_i)
  );

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: base+k, mode 1: -(base+k), mode 2: ~(base+k)
  function automatic logic [BW-1:0] ramp(input int base, input int mode);
    logic [BW-1:0] b;
    logic [DW-1:0] v;
    b = '0;
    for (int k = 0; k < N; k++) begin
      v = DW'(base + k);
      if (mode == 1) v = DW'(-(base + k));
      else if (mode == 2) v = ~v;
      b[k*DW +: DW] = v;
    end
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_valid = 1'b1;
    in_real  = r;
    in_imag  = i;
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard: record accepted samples, compare each transferred frame in order.
  always @(negedge clk) begin
    logic [BW-1:0] er, ei;
    logic [2*DW-1:0] s;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() < N) begin
          check("sb_underflow", BW'(sb.size()), BW'(N));
        end else begin
          for (int k = 0; k < N; k++) begin
            s = sb.pop_front();
            er[k*DW +: DW] = s[2*DW-1:DW];
            ei[k*DW +: DW] = s[DW-1:0];
          end
          check("sb_real", out_r, er);
          check("sb_imag", out_i, ei);
        end
        frames_seen++;
      end
      if (in_valid && in_ready) sb.push_back({in_real, in_imag});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drops;
    int f0;
    int sent;

    // 1. Reset state, then a single frame with out_ready=1.
    tick(); tick();
    check("rst_in_ready", BW'(in_ready), '0);
    check("rst_out_valid", BW'(out_valid), '0);
    check("rst_bus_real", out_r, '0);
    check("rst_bus_imag", out_i, '0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", BW'(in_ready), 1);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) check("t1_no_early_valid", BW'(out_valid), '0);
      send(DW'(k), DW'(-k));
    end
    check("t1_out_valid", BW'(out_valid), 1);
    check("t1_real", out_r, ramp(0, 0));
    check("t1_imag", out_i, ramp(0, 1));
    tick();
    check("t1_valid_drop", BW'(out_valid), '0);
    check("t1_bus_zero", out_r, '0);

    // 2. Fill both banks with out_ready=0, then drain; 6. ignored input when full.
    out_ready = 1'b0;
    for (int v = 0; v < 2 * N; v++) send(DW'(v), ~DW'(v));
    check("t2_in_ready_low", BW'(in_ready), '0);
    check("t2_out_valid", BW'(out_valid), 1);
    check("t2_f0_real", out_r, ramp(0, 0));
    check("t2_f0_imag", out_i, ramp(0, 2));
    in_valid = 1'b1;
    in_real  = 8'hAA;
    in_imag  = 8'h55;
    for (int c = 0; c < 4; c++) tick();
    in_valid = 1'b0;
    check("t6_hold_real", out_r, ramp(0, 0));
    check("t6_hold_imag", out_i, ramp(0, 2));
    check("t6_in_ready_low", BW'(in_ready), '0);
    out_ready = 1'b1;
    tick();
    check("t2_f1_real", out_r, ramp(32, 0));
    check("t2_f1_imag", out_i, ramp(32, 2));
    check("t2_in_ready_back", BW'(in_ready), 1);
    tick();
    check("t2_drained", BW'(out_valid), '0);

    // 3. Continuous streaming for 4 frames.
    drops = 0;
    f0 = frames_seen;
    in_valid = 1'b1;
    for (int c = 0; c < 4 * N; c++) begin
      in_real = DW'(c);
      in_imag = DW'(c) ^ 8'h5A;
      if (!in_ready) drops++;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("t3_ready_drops", BW'(drops), '0);
    check("t3_frames", BW'(frames_seen - f0), 4);

    // 4. Random valid/ready gaps over 100 frames.
    sent = 0;
    f0 = frames_seen;
    for (int cyc = 0; cyc < 20000 && (frames_seen - f0) < 100; cyc++) begin
      in_valid  = (sent < 100 * N) && ($urandom_range(0, 1) == 1);
      in_real   = DW'($urandom);
      in_imag   = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("t4_frames", BW'(frames_seen - f0), 100);
    check("t4_sb_empty", BW'(sb.size()), '0);

    // 5. Reset mid-frame with a held frame present.
    for (int k = 0; k < N; k++) send(DW'(200 + k), DW'(-(200 + k)));
    for (int k = 0; k < 17; k++) send(DW'(7 + k), DW'(k));
    check("t5_held_valid", BW'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", BW'(out_valid), '0);
    check("t5_rst_real", out_r, '0);
    check("t5_rst_ready", BW'(in_ready), '0);
    tick();
    check("t5_rst_valid2", BW'(out_valid), '0);
    check("t5_rst_imag", out_i, '0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) send(DW'(100 + k), DW'(-(100 + k)));
    check("t5_out_valid", BW'(out_valid), 1);
    check("t5_real", out_r, ramp(100, 0));
    check("t5_imag", out_i, ramp(100, 1));
    out_ready = 1'b1;
    tick();
    check("t5_drained", BW'(out_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
